// File: rtl/burst_sum_accumulator.sv
// burst_sum_accumulator
//   Folds a burst of BURST_LEN operands, received over a valid/ready stream,
//   into a running sum through an internal ripple_carry_adder (carryin = 0).
//   Tracks a sticky carry-out overflow flag and presents the final sum on a
//   held valid/ready output handshake.
//
//   Optional build macro: ACC_SATURATE_EN
//     defined   -> on any carry-out (or once overflow is set) the sum clamps
//                  to all ones.
//     undefined -> the sum wraps modulo 2^NUMBITS; overflow still records carry.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-low reset
//   start        in   begins a burst (honoured only in IDLE)
//   in_valid     in   operand valid
//   in_ready     out  operand accepted this cycle (ACCUM)
//   in_data      in   operand [NUMBITS]
//   out_valid    out  final sum available (DONE)
//   out_ready    in   consumer accepts the sum
//   out_sum      out  accumulated sum [NUMBITS]
//   out_overflow out  sticky carry-out flag
//   out_count    out  operands accepted in current/last burst [CNTW]
//   busy         out  state is not IDLE

module ripple_carry_adder #(
  parameter int NUMBITS = 32
) (
  input  logic [NUMBITS-1:0] a,
  input  logic [NUMBITS-1:0] b,
  input  logic               carryin,
  output logic [NUMBITS-1:0] sum,
  output logic               carryout
);

  logic [NUMBITS:0] carry;

  assign carry[0] = carryin;

  for (genvar i = 0; i < NUMBITS; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carryout = carry[NUMBITS];

endmodule

module burst_sum_accumulator #(
  parameter  int NUMBITS   = 32,
  parameter  int BURST_LEN = 8,
  localparam int CNTW      = $clog2(BURST_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] out_sum,
  output logic               out_overflow,
  output logic [CNTW-1:0]    out_count,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BURST_LEN - 1);

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [NUMBITS-1:0] acc_q, acc_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [NUMBITS-1:0] add_sum;
  logic               add_co;
  logic               beat;

  ripple_carry_adder #(
    .NUMBITS (NUMBITS)
  ) u_adder (
    .a        (acc_q),
    .b        (in_data),
    .carryin  (1'b0),
    .sum      (add_sum),
    .carryout (add_co)
  );

  // in_ready_q is high exactly in ACCUM, so this is the accepted-operand strobe.
  assign beat = in_valid && in_ready_q;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      end
      ACCUM: begin
        if (beat) begin
          ovf_d = ovf_q | add_co;
          cnt_d = cnt_q + CNTW'(1);
`ifdef ACC_SATURATE_EN
          // Once any add has overflowed the sum stays clamped for the burst.
          acc_d = (add_co || ovf_q) ? '1 : add_sum;
`else
          acc_d = add_sum;
`endif
        end
      end
      default: ;
    endcase
  end

  // State and handshake flags live in one register block; the flags are
  // registered alongside the state so outputs never see an input path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat && (cnt_q == LAST_BEAT)) begin
            state_q     <= DONE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
  assign out_count    = cnt_q;

endmodule

// File: tb/tb_burst_sum_accumulator.sv
// Bench for burst_sum_accumulator (NUMBITS = 32, BURST_LEN = 4).
// The driver issues bursts and pushes each expected final result into a
// scoreboard queue; a separate monitor pops and compares on every output
// handshake. Build with +define+ACC_SATURATE_EN to check the saturating build.

module tb_burst_sum_accumulator;

  localparam int NB   = 32;
  localparam int BL   = 4;
  localparam int CW   = $clog2(BL + 1);

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_sum;
  logic          out_overflow;
  logic [CW-1:0] out_count;
  logic          busy;

  burst_sum_accumulator #(
    .NUMBITS   (NB),
    .BURST_LEN (BL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_count    (out_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] sum;
    logic          ovf;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;

  logic [NB-1:0] beats [BL];
  logic [NB-1:0] m_acc;
  logic          m_ovf;
  int            m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned add with 33-bit headroom; the top bit is the carry.
  task automatic model_add(input logic [NB-1:0] d);
    logic [NB:0] wide;
    wide  = {1'b0, m_acc} + {1'b0, d};
    m_ovf = m_ovf | wide[NB];
`ifdef ACC_SATURATE_EN
    m_acc = m_ovf ? {NB{1'b1}} : wide[NB-1:0];
`else
    m_acc = wide[NB-1:0];
`endif
    m_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),     64'd0);
    check({tag, "_out_valid"}, 64'(out_valid),    64'd0);
    check({tag, "_busy"},      64'(busy),         64'd0);
    check({tag, "_out_sum"},   64'(out_sum),      64'd0);
    check({tag, "_out_ovf"},   64'(out_overflow), 64'd0);
    check({tag, "_out_count"}, 64'(out_count),    64'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_ready", 64'(in_ready),  64'd1);
    check("start_busy",     64'(busy),      64'd1);
    check("start_count",    64'(out_count), 64'd0);
    check("start_sum",      64'(out_sum),   64'd0);
    check("start_ovf",      64'(out_overflow), 64'd0);
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic send_beat(input logic [NB-1:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("gap_sum_hold",   64'(out_sum),   64'(m_acc));
      check("gap_count_hold", 64'(out_count), 64'(m_cnt));
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    model_add(d);
  endtask

  // One full burst from IDLE through the output handshake. use_exp selects a
  // hand-written expected result over the reference model's.
  task automatic run_burst(input int gap, input int hold, input bit use_exp,
                           input logic [NB-1:0] exp_sum, input logic exp_ovf);
    exp_t e;
    do_start();
    for (int b = 0; b < BL; b++) begin
      send_beat(beats[b], gap);
      if (b < BL - 1) begin
        check("accum_in_ready", 64'(in_ready),  64'd1);
        check("accum_sum",      64'(out_sum),   64'(m_acc));
        check("accum_count",    64'(out_count), 64'(m_cnt));
      end
    end
    // Result must be presented on the edge right after the last beat.
    check("last_beat_out_valid", 64'(out_valid), 64'd1);
    check("done_in_ready",       64'(in_ready),  64'd0);
    e.sum = use_exp ? exp_sum : m_acc;
    e.ovf = use_exp ? exp_ovf : m_ovf;
    e.cnt = CW'(BL);
    sb.push_back(e);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (h == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_out_valid", 64'(out_valid),    64'd1);
      check("hold_in_ready",  64'(in_ready),     64'd0);
      check("hold_sum",       64'(out_sum),      64'(e.sum));
      check("hold_ovf",       64'(out_overflow), 64'(e.ovf));
      check("hold_count",     64'(out_count),    64'(e.cnt));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", 64'(out_valid), 64'd0);
    check("post_hs_busy",      64'(busy),      64'd0);
    check("retained_sum",      64'(out_sum),   64'(e.sum));
    check("retained_count",    64'(out_count), 64'(e.cnt));
  endtask

  // Monitor: compare against the scoreboard on each output handshake.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_sum",   64'(out_sum),      64'(e.sum));
        check("sb_ovf",   64'(out_overflow), 64'(e.ovf));
        check("sb_count", 64'(out_count),    64'(e.cnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_acc     = '0;
    m_ovf     = 1'b0;
    m_cnt     = 0;

    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("idle");

    // Small sum
    beats[0] = 32'd1; beats[1] = 32'd2; beats[2] = 32'd3; beats[3] = 32'd4;
    run_burst(0, 0, 1'b1, 32'h0000000A, 1'b0);

    // No-carry pattern
    beats[0] = 32'h12345678; beats[1] = 32'h87654321; beats[2] = '0; beats[3] = '0;
    run_burst(0, 0, 1'b1, 32'h99999999, 1'b0);

    // Carry-out
    beats[0] = 32'hFFFFFFFF; beats[1] = 32'h00000002; beats[2] = '0; beats[3] = '0;
`ifdef ACC_SATURATE_EN
    run_burst(0, 0, 1'b1, 32'hFFFFFFFF, 1'b1);
`else
    run_burst(0, 0, 1'b1, 32'h00000001, 1'b1);
`endif

    // Idle gaps between beats
    beats[0] = 32'd5; beats[1] = 32'd6; beats[2] = 32'd7; beats[3] = 32'd8;
    run_burst(3, 0, 1'b1, 32'h0000001A, 1'b0);

    // Held DONE with a start pulse that must be ignored
    beats[0] = 32'd10; beats[1] = 32'd20; beats[2] = 32'd30; beats[3] = 32'd40;
    run_burst(0, 5, 1'b1, 32'd100, 1'b0);

    // Reset mid-burst discards the partial sum
    do_start();
    send_beat(32'd9, 0);
    send_beat(32'd9, 0);
    check("pre_reset_sum", 64'(out_sum), 64'd18);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midburst_reset");
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_reset");
    beats[0] = 32'd1; beats[1] = 32'd1; beats[2] = 32'd1; beats[3] = 32'd1;
    run_burst(0, 0, 1'b1, 32'h00000004, 1'b0);

    // Randomized bursts against the reference model
    for (int n = 0; n < 24; n++) begin
      for (int b = 0; b < BL; b++) begin
        case ($urandom_range(0, 3))
          0:       beats[b] = $urandom_range(0, 255);
          1:       beats[b] = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
          default: beats[b] = $urandom;
        endcase
      end
      run_burst($urandom_range(0, 2), $urandom_range(0, 3), 1'b0, '0, 1'b0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
